// File: rtl/tb_memory_pkg.sv
// Shared types and sizing helpers for the multi-port regbus test memory.
package tb_memory_pkg;

   localparam int unsigned AddrWidth   = 48;
   localparam int unsigned DataWidth   = 32;
   localparam int unsigned StrbWidth   = DataWidth / 8;
   localparam int unsigned WordOffBits = $clog2(StrbWidth);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 write;
      logic [DataWidth-1:0] wdata;
      logic [StrbWidth-1:0] wstrb;
      logic                 valid;
   } req_t;

   typedef struct packed {
      logic [DataWidth-1:0] rdata;
      logic                 error;
      logic                 ready;
   } rsp_t;

   // Index width that stays legal for a single-entry range.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tb_memory_regbus_mp_rr_arb.sv
// Round-robin grant over the regbus request valids; priority starts after the last taken grant.
// Latency: combinational grant, pointer updates on the edge where the grant is taken.
// Backpressure: losers are not acknowledged and simply keep requesting.
module tb_memory_regbus_mp_rr_arb #(
   parameter int unsigned NumPorts = 2,
   parameter int unsigned IdxWidth = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumPorts-1:0] req,
   input  logic                take,
   output logic                gnt_vld,
   output logic [IdxWidth-1:0] gnt_idx
);

   localparam int N = int'(NumPorts);

   logic [IdxWidth-1:0] ptr_q;

   always_comb begin
      int cand;
      cand    = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         cand = (int'(ptr_q) + i) % N;
         if (!gnt_vld && req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = IdxWidth'(cand);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (take && gnt_vld) begin
         ptr_q <= (gnt_idx == IdxWidth'(N - 1)) ? '0 : gnt_idx + IdxWidth'(1);
      end
   end

endmodule

// File: rtl/tb_memory_regbus_mp.sv
// Multi-port regbus test memory: several requesters share one word array, with range-error decode.
// Latency: ready Latency cycles after valid is first seen in IDLE; one access in flight at a time.
// Backpressure: ungranted requesters hold valid and fields until their own ready pulse.
module tb_memory_regbus_mp
   import tb_memory_pkg::*;
#(
   parameter int unsigned          NumPorts = 2,
   parameter int unsigned          Depth    = 1024,
   parameter logic [AddrWidth-1:0] BaseAddr = '0,
   parameter int unsigned          Latency  = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  req_t        req_i [NumPorts],
   output rsp_t        rsp_o [NumPorts],
   output logic        busy_o,
   output logic [31:0] access_cnt_o
);

   localparam int unsigned          IdxWidth     = $clog2(Depth);
   localparam int unsigned          PortIdxWidth = idx_width(NumPorts);
   localparam int unsigned          CntWidth     = idx_width(Latency);
   localparam logic [AddrWidth-1:0] DepthWords   = AddrWidth'(Depth);

   state_e                  state_q, state_d;
   logic [CntWidth-1:0]     lat_q, lat_d;
   logic [PortIdxWidth-1:0] port_q;
   logic                    write_q, hit_q;
   logic [IdxWidth-1:0]     word_q;
   logic [DataWidth-1:0]    wdata_q, rdata_q;
   logic [StrbWidth-1:0]    wstrb_q;
   logic [31:0]             cnt_q;
   logic [DataWidth-1:0]    mem_q [Depth];

   logic [NumPorts-1:0]     req_vld;
   logic                    gnt_vld;
   logic [PortIdxWidth-1:0] gnt_idx;
   logic [AddrWidth-1:0]    gnt_off;
   logic                    gnt_hit;
   logic [IdxWidth-1:0]     gnt_word;
   logic                    grant, to_resp, rd_hit, rd_write;
   logic [IdxWidth-1:0]     rd_word;

   always_comb begin
      req_vld = '0;
      for (int p = 0; p < int'(NumPorts); p++) req_vld[p] = req_i[p].valid;
   end

   tb_memory_regbus_mp_rr_arb #(
      .NumPorts (NumPorts),
      .IdxWidth (PortIdxWidth)
   ) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req     (req_vld),
      .take    (grant),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   // Addresses below BaseAddr wrap to huge offsets, so both bounds are checked explicitly.
   always_comb begin
      gnt_off  = req_i[gnt_idx].addr - BaseAddr;
      gnt_hit  = (req_i[gnt_idx].addr >= BaseAddr) && ((gnt_off >> WordOffBits) < DepthWords);
      gnt_word = gnt_off[WordOffBits +: IdxWidth];
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      grant   = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               grant   = 1'b1;
               lat_d   = CntWidth'(Latency - 1);
               state_d = (Latency == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            lat_d = lat_q - CntWidth'(1);
            if (lat_q == CntWidth'(1)) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With Latency==1 the read is issued on the grant edge, before the fields are latched.
   assign to_resp  = (state_d == RESP) && (state_q != RESP);
   assign rd_hit   = grant ? gnt_hit : hit_q;
   assign rd_write = grant ? req_i[gnt_idx].write : write_q;
   assign rd_word  = grant ? gnt_word : word_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         lat_q   <= '0;
         port_q  <= '0;
         write_q <= 1'b0;
         hit_q   <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         if (grant) begin
            port_q  <= gnt_idx;
            write_q <= req_i[gnt_idx].write;
            hit_q   <= gnt_hit;
            word_q  <= gnt_word;
            wdata_q <= req_i[gnt_idx].wdata;
            wstrb_q <= req_i[gnt_idx].wstrb;
         end
         if (state_q == RESP && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
      end
   end

   // No reset here: memory contents survive rst_i, and an aborted access must not commit.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (to_resp) rdata_q <= (rd_hit && !rd_write) ? mem_q[rd_word] : '0;
         if (state_q == RESP && write_q && hit_q) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
               if (wstrb_q[b]) mem_q[word_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < int'(NumPorts); p++) begin
         rsp_o[p] = '0;
         if (state_q == RESP && port_q == PortIdxWidth'(p)) begin
            rsp_o[p].ready = 1'b1;
            rsp_o[p].error = !hit_q;
            rsp_o[p].rdata = rdata_q;
         end
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign access_cnt_o = cnt_q;

   property p_hold_valid;
      @(posedge clk_i) disable iff (rst_i) (state_q != IDLE) |-> req_i[port_q].valid;
   endproperty
   a_hold_valid: assert property (p_hold_valid);

endmodule

// File: tb/tb_tb_memory_regbus_mp.sv
// Directed bench for the multi-port regbus memory with a word-array model and per-cycle response check.
module tb_tb_memory_regbus_mp;
   import tb_memory_pkg::*;

   localparam int          NP    = 2;
   localparam int          DEPTH = 1024;
   localparam logic [47:0] BASE  = 48'h1000;
   localparam int          LAT   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   req_t        req [NP];
   rsp_t        rsp [NP];
   logic        busy;
   logic [31:0] cnt;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          n_ready = 0;
   int          exp_cnt = 0;
   int          mon_nrdy;
   bit          mon_en = 1'b0;
   int          gnt_log[$];
   logic [31:0] mem_m [int];
   int          l0, l1, nr0;
   int          exp_order [6] = '{0, 1, 0, 1, 0, 1};

   logic [31:0] rd;
   logic        er;
   int          lat;

   tb_memory_regbus_mp #(
      .NumPorts (NP),
      .Depth    (DEPTH),
      .BaseAddr (BASE),
      .Latency  (LAT)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_i        (req),
      .rsp_o        (rsp),
      .busy_o       (busy),
      .access_cnt_o (cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit m_hit(input logic [47:0] a);
      logic [47:0] off;
      off = a - BASE;
      return (a >= BASE) && ((off >> 2) < 48'(DEPTH));
   endfunction

   function automatic int m_word(input logic [47:0] a);
      logic [47:0] off;
      off = a - BASE;
      return int'(off >> 2);
   endfunction

   // Expected response for the access currently presented on port p.
   task automatic model_resp(input int p);
      logic [31:0] exp_rd, v;
      logic        exp_er;
      int          w;
      w = m_word(req[p].addr);
      exp_rd = '0;
      exp_er = 1'b0;
      if (!m_hit(req[p].addr)) begin
         exp_er = 1'b1;
      end else if (req[p].write) begin
         if (!rst) begin
            v = mem_m.exists(w) ? mem_m[w] : 32'h0;
            for (int b = 0; b < 4; b++) if (req[p].wstrb[b]) v[8*b +: 8] = req[p].wdata[8*b +: 8];
            mem_m[w] = v;
         end
      end else begin
         exp_rd = mem_m.exists(w) ? mem_m[w] : 32'hx;
      end
      check("rsp_rdata", rsp[p].rdata, exp_rd);
      check("rsp_error", 32'(rsp[p].error), 32'(exp_er));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_nrdy = 0;
         check("access_cnt", cnt, exp_cnt);
         for (int p = 0; p < NP; p++) begin
            if (rsp[p].ready) begin
               mon_nrdy++;
               n_ready++;
               if (!rst) gnt_log.push_back(p);
               model_resp(p);
            end else begin
               check("idle_rdata", rsp[p].rdata, 0);
               check("idle_error", 32'(rsp[p].error), 0);
            end
         end
         if (mon_nrdy > 0) check("ready_busy", 32'(busy), 1);
         check("ready_onehot", 32'(mon_nrdy <= 1), 1);
         if (rst) exp_cnt = 0;
         else     exp_cnt += mon_nrdy;
      end
   end

   task automatic access(input int p, input logic [47:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rdo, output logic ero, output int lato);
      int t0;
      bit got;
      got  = 1'b0;
      rdo  = '0;
      ero  = 1'b0;
      lato = -1;
      @(posedge clk);
      #1;
      req[p].addr  = a;
      req[p].write = we;
      req[p].wdata = wd;
      req[p].wstrb = st;
      req[p].valid = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (rsp[p].ready) begin
            got  = 1'b1;
            rdo  = rsp[p].rdata;
            ero  = rsp[p].error;
            lato = cyc - t0;
            break;
         end
      end
      check("ready_seen", 32'(got), 1);
   endtask

   task automatic drop(input int p);
      @(posedge clk);
      #1 req[p].valid = 1'b0;
   endtask

   task automatic single(input int p, input logic [47:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rdo, output logic ero, output int lato);
      access(p, a, we, wd, st, rdo, ero, lato);
      drop(p);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int p = 0; p < NP; p++) req[p].valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_cnt", cnt, 0);
      check("rst_ready", 32'(rsp[0].ready), 0);
   endtask

   task automatic seq(input int p, output int first_lat);
      logic [31:0] r;
      logic        e;
      int          lt;
      first_lat = -1;
      for (int i = 0; i < 3; i++) begin
         access(p, BASE + 48'h40 + 48'(p * 16 + i * 4), 1'b1, 32'hC0DE0000 + 32'(p * 16 + i), 4'hF, r, e, lt);
         if (i == 0) first_lat = lt;
      end
      drop(p);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int p = 0; p < NP; p++) req[p] = '0;
      @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_cnt", cnt, 0);
      check("rst_ready", 32'(rsp[0].ready), 0);

      single(0, BASE + 48'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, er, lat);
      check("wr_latency", lat, LAT);
      check("wr_error", 32'(er), 0);
      @(negedge clk);
      check("cnt_after_one", cnt, 1);

      single(0, BASE + 48'h10, 1'b0, '0, 4'h0, rd, er, lat);
      check("rd_back", rd, 32'hDEADBEEF);
      check("rd_latency", lat, LAT);
      single(0, BASE + 48'h10, 1'b1, 32'h0000AA00, 4'b0010, rd, er, lat);
      single(0, BASE + 48'h10, 1'b0, '0, 4'h0, rd, er, lat);
      check("strb_merge", rd, 32'hDEADAAEF);
      single(1, BASE + 48'h13, 1'b0, '0, 4'h0, rd, er, lat);
      check("low_bits_ignored", rd, 32'hDEADAAEF);

      single(0, BASE, 1'b1, 32'hA5A5A5A5, 4'hF, rd, er, lat);
      single(1, BASE + 48'((DEPTH - 1) * 4), 1'b1, 32'h0BADF00D, 4'hF, rd, er, lat);
      single(0, BASE + 48'((DEPTH - 1) * 4), 1'b0, '0, 4'h0, rd, er, lat);
      check("last_word", rd, 32'h0BADF00D);
      check("last_word_err", 32'(er), 0);

      single(0, BASE + 48'(DEPTH * 4), 1'b0, '0, 4'h0, rd, er, lat);
      check("oor_rd_err", 32'(er), 1);
      check("oor_rd_data", rd, 0);
      single(1, BASE + 48'(DEPTH * 4), 1'b1, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      check("oor_wr_err", 32'(er), 1);
      single(0, BASE - 48'h4, 1'b0, '0, 4'h0, rd, er, lat);
      check("below_base_err", 32'(er), 1);
      single(0, BASE, 1'b0, '0, 4'h0, rd, er, lat);
      check("oor_no_alias", rd, 32'hA5A5A5A5);

      do_reset();
      gnt_log.delete();
      fork
         seq(0, l0);
         seq(1, l1);
      join
      check("grant_count", gnt_log.size(), 6);
      for (int i = 0; i < gnt_log.size() && i < 6; i++) check("grant_order", gnt_log[i], exp_order[i]);
      check("first_lat_p0", l0, LAT);
      check("first_lat_p1", l1, 2 * LAT + 1);
      @(negedge clk);
      check("cnt_after_six", cnt, 6);
      single(1, BASE + 48'h54, 1'b0, '0, 4'h0, rd, er, lat);
      check("contend_data", rd, 32'hC0DE0011);

      single(0, BASE + 48'h20, 1'b1, 32'hCAFEF00D, 4'hF, rd, er, lat);
      nr0 = n_ready;
      @(posedge clk);
      #1;
      req[0].addr  = BASE + 48'h20;
      req[0].write = 1'b1;
      req[0].wdata = 32'h11111111;
      req[0].wstrb = 4'hF;
      req[0].valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("busy_in_wait", 32'(busy), 1);
      do_reset();
      repeat (6) @(negedge clk);
      check("abort_no_ready", n_ready, nr0);
      single(0, BASE + 48'h20, 1'b0, '0, 4'h0, rd, er, lat);
      check("abort_no_write", rd, 32'hCAFEF00D);

      single(1, BASE + 48'h14, 1'b1, 32'h12345678, 4'hF, rd, er, lat);
      do_reset();
      single(0, BASE + 48'h14, 1'b0, '0, 4'h0, rd, er, lat);
      check("retained", rd, 32'h12345678);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
